// File: rtl/rsenc_lfsr.sv
// rsenc_lfsr: systematic RS(255,239) encoder over GF(2^8), poly 0x11D.
// Define RSENC_CNT_OUT_EN to expose sym_cnt, the codeword position of dout.
module rsenc_lfsr #(
  parameter int NDATA = 239
) (
  input  logic       clk,
  input  logic       clr,
  input  logic       enable,
  input  logic [7:0] din,
  input  logic       din_valid,
  output logic       din_ready,
  output logic [7:0] dout,
  output logic       dout_valid,
  input  logic       dout_ready,
  output logic       dout_sof,
  output logic       dout_eof
`ifdef RSENC_CNT_OUT_EN
  ,
  output logic [7:0] sym_cnt
`endif
);

  function automatic logic [7:0] gf_mul(
    input logic [7:0] a,
    input logic [7:0] b
  );
    logic [7:0] p;
    logic [7:0] x;
    p = '0;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1d : 8'h00);
    end
    return p;
  endfunction

  // g(x) = prod (x + alpha^i), i = 0..15; g16 = 1 is implicit
  function automatic logic [127:0] gen_poly();
    logic [7:0]   g [17];
    logic [7:0]   root;
    logic [127:0] r;
    for (int j = 0; j < 17; j++) g[j] = (j == 0) ? 8'h01 : 8'h00;
    root = 8'h01;
    for (int i = 0; i < 16; i++) begin
      for (int j = 16; j > 0; j--)
        g[j] = g[j-1] ^ gf_mul(g[j], root);
      g[0] = gf_mul(g[0], root);
      root = gf_mul(root, 8'h02);
    end
    r = '0;
    for (int j = 0; j < 16; j++) r[j*8 +: 8] = g[j];
    return r;
  endfunction

  localparam logic [127:0] GPOLY = gen_poly();
  localparam logic [7:0]   LAST  = 8'(NDATA - 1);

  typedef enum logic [1:0] {
    IDLE,
    DATA,
    PARITY
  } state_t;

  state_t     state;
  logic [7:0] cnt;
  logic [7:0] par [16];
  logic [7:0] fb;
  logic       adv;
  logic       load;
  logic       accept;

  assign adv       = ~dout_valid | dout_ready;
  assign load      = enable & adv;
  assign din_ready = ~clr & load & (state != PARITY);
  assign accept    = din_valid & din_ready;
  assign fb        = din ^ par[15];

  always_ff @(posedge clk) begin
    if (clr) begin
      state      <= IDLE;
      cnt        <= '0;
      dout       <= '0;
      dout_valid <= 1'b0;
      dout_sof   <= 1'b0;
      dout_eof   <= 1'b0;
      for (int i = 0; i < 16; i++) par[i] <= '0;
    end else if (load) begin
      unique case (state)
        IDLE, DATA: begin
          dout_eof <= 1'b0;
          if (accept) begin
            dout       <= din;
            dout_valid <= 1'b1;
            dout_sof   <= (state == IDLE);
            par[0]     <= gf_mul(fb, GPOLY[7:0]);
            for (int i = 1; i < 16; i++)
              par[i] <= par[i-1] ^ gf_mul(fb, GPOLY[i*8 +: 8]);
            if (cnt == LAST) begin
              state <= PARITY;
              cnt   <= '0;
            end else begin
              state <= DATA;
              cnt   <= cnt + 8'd1;
            end
          end else begin
            dout_valid <= 1'b0;
            dout_sof   <= 1'b0;
          end
        end
        PARITY: begin
          dout       <= par[15];
          dout_valid <= 1'b1;
          dout_sof   <= 1'b0;
          par[0]     <= '0;
          for (int i = 1; i < 16; i++) par[i] <= par[i-1];
          if (cnt == 8'd15) begin
            dout_eof <= 1'b1;
            state    <= IDLE;
            cnt      <= '0;
          end else begin
            dout_eof <= 1'b0;
            cnt      <= cnt + 8'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef RSENC_CNT_OUT_EN
  always_ff @(posedge clk) begin
    if (clr) begin
      sym_cnt <= '0;
    end else if (load && (accept || state == PARITY)) begin
      sym_cnt <= (state == IDLE) ? 8'd0 : sym_cnt + 8'd1;
    end
  end
`endif

endmodule
